data_bus_buffer: RTL and testbench
==================================

// Module: data_bus_buffer
// PURPOSE
//   8-bit bidirectional data bus buffer for the 8259A PIC. Sits between the CPU
//   system data bus (D) and the PIC internal bus (PCadr).
//   Tri-state pass-through is gated by en; direction is selected by ino.
//   Also captures each CPU-written byte into a register and flags it with a
//   one-cycle strobe for the control logic (ICW/OCW decode).
// PARAMETERS
//   WIDTH  8  data bus width in bits (D, PCadr, wr_data)
// PORTS
//   clk      in     1      system clock; all registers update on the rising edge
//   rst      in     1      synchronous, active-high reset
//   en       in     1      buffer enable; 0 puts both D and PCadr at high-Z
//   ino      in     1      direction: 1 = inbound D->PCadr, 0 = outbound PCadr->D
//   D        inout  WIDTH  CPU system data bus
//   PCadr    inout  WIDTH  PIC internal data bus
//   wr_data  out    WIDTH  last byte captured from D during an inbound transfer
//   wr_stb   out    1      one-cycle pulse: wr_data was updated this cycle
//   busy     out    1      registered copy of en; 1 while the buffer is driving
// BEHAVIOUR
//   Drive paths (combinational, no latency):
//   - en=1, ino=1, rst=0: PCadr = D; D is high-Z (not driven by this block).
//   - en=1, ino=0, rst=0: D = PCadr; PCadr is high-Z.
//   - en=0: D and PCadr both high-Z, regardless of ino.
//   - rst=1: D and PCadr both high-Z, regardless of en/ino. This override is
//     combinational so a reset mid-transfer releases both buses immediately.
//   - A change of ino while en=1 reverses the direction immediately. The
//     block never drives both ports at once (break-before-make is implied).
//   Capture logic (synchronous):
//   - inb = en & ino; inb_q = inb registered each cycle.
//   - Rising edge of inb (inb=1, inb_q=0) at a clk edge: wr_data <= D and
//     wr_stb <= 1 for exactly one cycle.
//   - inb held high for several cycles produces a single capture and a single
//     strobe, on the first cycle only. The byte present on that edge is kept.
//   - X/Z bits on D are captured as-is; no filtering.
//   - Outbound transfers (ino=0) never modify wr_data and never pulse wr_stb.
//   - A direction flip 0->1 with en held high counts as a new inbound edge.
//   - busy <= en every cycle.
//   Reset (rst=1 at a clk edge):
//   - wr_data = 0, wr_stb = 0, busy = 0, inb_q = 0.
//   - If inb=1 on the first clock after rst drops, that is an edge and captures.
//   Width rules: straight bit-for-bit copy, D[i]<->PCadr[i]; no inversion,
//     no parity.
// TESTING
//   1. rst=1 for 2 clks, en=1, ino=1, D=8'hAA -> D and PCadr both Z;
//      wr_data=0, wr_stb=0, busy=0.
//   2. rst=0, en=0, D=8'h00, PCadr externally undriven -> PCadr=Z, D=8'h00;
//      wr_stb stays 0.
//   3. en=1, ino=1, D=8'hAA -> PCadr=8'hAA in the same delta;
//      next edge: wr_data=8'hAA, wr_stb=1 for one cycle, busy=1.
//   4. Hold en=1, ino=1 for 4 clks while D changes to 8'h55 -> PCadr follows
//      8'h55; wr_data stays 8'hAA; no further wr_stb.
//   5. en=1, ino=0, PCadr driven 8'h3C, D released -> D=8'h3C; PCadr not driven
//      by DUT; wr_data unchanged.
//   6. Inbound active with D=8'hF0, assert rst mid-transfer -> D and PCadr go
//      Z immediately; next edge wr_data=0, busy=0.

Source files
------------

// File: rtl/data_bus_buffer_if.sv
// Control/status bundle for the 8259A data bus buffer: direction/enable in,
// captured write byte, strobe and busy flag out.
interface data_bus_buffer_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             ino;
    logic [WIDTH-1:0] wr_data;
    logic             wr_stb;
    logic             busy;

    modport master (
        output en, ino,
        input  wr_data, wr_stb, busy
    );

    modport slave (
        input  en, ino,
        output wr_data, wr_stb, busy
    );
endinterface

// File: rtl/data_bus_buffer.sv
// 8259A bidirectional data bus buffer: gated tri-state pass-through between
// D and PCadr, plus a one-shot capture of each inbound CPU byte.
module data_bus_buffer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    data_bus_buffer_if.slave     bus,
    inout  wire  [WIDTH-1:0]     D,
    inout  wire  [WIDTH-1:0]     PCadr
);
    logic inb;
    logic inb_q;
    logic drv_pcadr;
    logic drv_d;

    // Reset gates the drivers combinationally so a mid-transfer reset frees
    // both buses at once; the two enables are mutually exclusive via ino.
    assign inb       = bus.en & bus.ino;
    assign drv_pcadr = inb & ~rst;
    assign drv_d     = bus.en & ~bus.ino & ~rst;

    assign PCadr = drv_pcadr ? D     : {WIDTH{1'bz}};
    assign D     = drv_d     ? PCadr : {WIDTH{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            inb_q       <= 1'b0;
            bus.wr_data <= '0;
            bus.wr_stb  <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            inb_q      <= inb;
            bus.busy   <= bus.en;
            bus.wr_stb <= inb & ~inb_q;
            // Only the first cycle of an inbound burst is captured.
            if (inb && !inb_q)
                bus.wr_data <= D;
        end
    end
endmodule

// File: tb/tb_data_bus_buffer.sv
// Bench for data_bus_buffer: directed spec scenarios followed by random
// cycles, all checked against a transaction-level model of the buffer.
module tb_data_bus_buffer;
    logic       clk;
    logic       rst;
    logic [7:0] d_drv, p_drv;
    logic       d_oe, p_oe;
    wire  [7:0] D;
    wire  [7:0] PCadr;
    int         total;
    int         bad;

    // Model state: last captured byte, strobe, busy, and whether the
    // previous cycle was already an inbound transfer.
    logic [7:0] m_wr_data;
    logic       m_wr_stb;
    logic       m_busy;
    logic       m_in_prev;

    data_bus_buffer_if #(.WIDTH(8)) bus ();

    data_bus_buffer #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .D     (D),
        .PCadr (PCadr)
    );

    assign D     = d_oe ? d_drv : 8'hzz;
    assign PCadr = p_oe ? p_drv : 8'hzz;

    // Undriven bus lines float high so "not driven" reads as 8'hFF.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (D[g]);
        pullup (PCadr[g]);
    end

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: the bench drives whichever side is the source
    // for the selected direction, checks both buses, then the registers.
    task automatic step(input logic r, input logic e, input logic i,
                        input logic [7:0] dv, input logic [7:0] pv);
        logic [7:0] exp_d, exp_p;
        logic       passing;
        rst     = r;
        bus.en  = e;
        bus.ino = i;
        d_drv   = dv;
        p_drv   = pv;
        d_oe    = i;
        p_oe    = !i;
        #1;
        passing = e && !r;
        if (i) begin
            exp_d = dv;
            exp_p = passing ? dv : 8'hFF;
        end else begin
            exp_p = pv;
            exp_d = passing ? pv : 8'hFF;
        end
        chk("pcadr", PCadr, exp_p);
        chk("d", D, exp_d);
        @(posedge clk);
        if (r) begin
            m_wr_data = 8'h00;
            m_wr_stb  = 1'b0;
            m_busy    = 1'b0;
            m_in_prev = 1'b0;
        end else begin
            m_wr_stb  = (e && i) && !m_in_prev;
            if (m_wr_stb) m_wr_data = dv;
            m_busy    = e;
            m_in_prev = e && i;
        end
        @(negedge clk);
        chk("wr_data", bus.wr_data, m_wr_data);
        chk("wr_stb", {7'd0, bus.wr_stb}, {7'd0, m_wr_stb});
        chk("busy", {7'd0, bus.busy}, {7'd0, m_busy});
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        clk       = 1'b0;
        m_wr_data = 8'h00;
        m_wr_stb  = 1'b0;
        m_busy    = 1'b0;
        m_in_prev = 1'b0;

        // Reset held two clocks with an inbound request pending.
        step(1'b1, 1'b1, 1'b1, 8'hAA, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'hAA, 8'h00);
        chk("rst_wr_data", bus.wr_data, 8'h00);

        // Disabled: nothing passes, no strobe.
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);

        // Inbound edge captures AA, then a held burst with new data.
        step(1'b0, 1'b1, 1'b1, 8'hAA, 8'h00);
        chk("cap_aa", bus.wr_data, 8'hAA);
        for (int k = 0; k < 4; k++)
            step(1'b0, 1'b1, 1'b1, 8'h55, 8'h00);
        chk("hold_aa", bus.wr_data, 8'hAA);

        // Outbound leaves the capture untouched.
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h3C);
        chk("out_keep", bus.wr_data, 8'hAA);

        // Flip back to inbound with en held: new edge captures F0,
        // then reset mid-transfer.
        step(1'b0, 1'b1, 1'b1, 8'hF0, 8'h00);
        chk("flip_cap", bus.wr_data, 8'hF0);
        step(1'b1, 1'b1, 1'b1, 8'hF0, 8'h00);
        chk("mid_rst", bus.wr_data, 8'h00);

        // First clock after reset with inbound active is an edge.
        step(1'b0, 1'b1, 1'b1, 8'h81, 8'h00);
        chk("post_rst_cap", bus.wr_data, 8'h81);

        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(15) == 0), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
